// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and constants for the ALU sequencer.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_SHR = 5'd2;
  localparam logic [4:0] OP_SHL = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_NOT = 5'd6;
  localparam logic [4:0] OP_GT  = 5'd7;
  localparam logic [4:0] OP_LT  = 5'd8;
  localparam logic [4:0] OP_EQ  = 5'd9;
  localparam logic [4:0] OP_NE  = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd11;
  localparam logic [4:0] OP_DIV = 5'd12;

  localparam logic [1:0] CMP_GT = 2'd0;
  localparam logic [1:0] CMP_LT = 2'd1;
  localparam logic [1:0] CMP_EQ = 2'd2;
  localparam logic [1:0] CMP_NE = 2'd3;

  localparam logic [31:0] RESULT_DIV0 = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MUL  = 3'd2,
    ST_DIV  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic logic is_compare(input logic [4:0] op);
    return (op >= OP_GT) && (op <= OP_NE);
  endfunction

endpackage

// File: rtl/alu_seq_compare.sv
// Combinational unsigned comparator: gt / lt / eq / ne selected by mode.
module alu_seq_compare
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             hit
);

  always_comb begin
    hit = 1'b0;
    case (mode)
      CMP_GT:  hit = (a > b);
      CMP_LT:  hit = (a < b);
      CMP_EQ:  hit = (a == b);
      CMP_NE:  hit = (a != b);
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response controller around an external 32-bit ALU; sequences
// multiply and divide as 32-step loops over the ALU adder/subtractor.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [4:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic             req_cin_i,
  input  logic             req_rot_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_flag_o,
  output logic             busy_o,
  output logic [4:0]       alu_sel_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic             alu_cin_o,
  output logic             alu_bin_o,
  output logic             alu_rot_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_cout_i
);

  state_t state_q, state_d;

  // a_q doubles as multiplicand (MUL) and quotient (DIV); b_q as multiplier
  // (MUL) and divisor (DIV); acc_q as accumulator (MUL) and remainder (DIV).
  logic [4:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q, acc_q, result_q;
  logic              cin_q, rot_q, flag_q;
  logic [ITER_W-1:0] cnt_q;

  logic             accept, last_iter, cmp_hit, trial_ge;
  logic [1:0]       cmp_mode;
  logic [WIDTH-1:0] cmp_a, cmp_b, trial, acc_next, rem_next, quo_next;

  assign accept    = (state_q == ST_IDLE) && req_valid_i;
  assign last_iter = (cnt_q == ITER_W'(WIDTH - 1));
  assign trial     = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};

  // One comparator serves both the compare ops and the divide restore test.
  always_comb begin
    cmp_mode = CMP_GT;
    cmp_a    = req_a_i;
    cmp_b    = req_b_i;
    if (state_q == ST_DIV) begin
      cmp_mode = CMP_LT;
      cmp_a    = trial;
      cmp_b    = b_q;
    end else begin
      case (req_op_i)
        OP_LT:   cmp_mode = CMP_LT;
        OP_EQ:   cmp_mode = CMP_EQ;
        OP_NE:   cmp_mode = CMP_NE;
        default: cmp_mode = CMP_GT;
      endcase
    end
  end

  alu_seq_compare #(.WIDTH(WIDTH)) u_compare (
    .mode (cmp_mode),
    .a    (cmp_a),
    .b    (cmp_b),
    .hit  (cmp_hit)
  );

  assign trial_ge = ~cmp_hit;
  assign acc_next = b_q[0] ? alu_result_i : acc_q;
  assign rem_next = trial_ge ? alu_result_i : trial;
  assign quo_next = {a_q[WIDTH-2:0], trial_ge};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_op_i <= OP_NOT)          state_d = ST_EXEC;
          else if (is_compare(req_op_i))   state_d = ST_RESP;
          else if (req_op_i == OP_MUL)     state_d = ST_MUL;
          else if (req_op_i == OP_DIV)     state_d = (req_b_i != '0) ? ST_DIV : ST_RESP;
          else                             state_d = ST_RESP;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_MUL:  if (last_iter) state_d = ST_RESP;
      ST_DIV:  if (last_iter) state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP);
    alu_sel_o   = '0;
    alu_a_o     = '0;
    alu_b_o     = '0;
    alu_cin_o   = 1'b0;
    alu_bin_o   = 1'b0;
    alu_rot_o   = 1'b0;
    case (state_q)
      ST_EXEC: begin
        alu_sel_o = op_q;
        alu_a_o   = a_q;
        alu_b_o   = b_q;
        alu_cin_o = cin_q;
        alu_bin_o = cin_q;
        alu_rot_o = rot_q;
      end
      ST_MUL: begin
        alu_sel_o = OP_ADD;
        alu_a_o   = acc_q;
        alu_b_o   = a_q;
      end
      ST_DIV: begin
        alu_sel_o = OP_SUB;
        alu_a_o   = trial;
        alu_b_o   = b_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; results are captured on the edge that enters RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cin_q    <= 1'b0;
      rot_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= req_op_i;
            a_q      <= req_a_i;
            b_q      <= req_b_i;
            cin_q    <= req_cin_i;
            rot_q    <= req_rot_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            if (is_compare(req_op_i)) begin
              result_q <= WIDTH'(cmp_hit);
            end else if (req_op_i == OP_DIV && req_b_i == '0) begin
              result_q <= RESULT_DIV0;
              flag_q   <= 1'b1;
            end else if (req_op_i > OP_DIV) begin
              flag_q   <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          result_q <= alu_result_i;
          flag_q   <= (op_q == OP_ADD || op_q == OP_SUB) ? alu_cout_i : 1'b0;
        end
        ST_MUL: begin
          acc_q <= acc_next;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + ITER_W'(1);
          if (last_iter) begin
            result_q <= acc_next;
            flag_q   <= 1'b0;
          end
        end
        ST_DIV: begin
          acc_q <= rem_next;
          a_q   <= quo_next;
          cnt_q <= cnt_q + ITER_W'(1);
          if (last_iter) begin
            result_q <= quo_next;
            flag_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_result_o = result_q;
  assign rsp_flag_o   = flag_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed bench for alu_sequencer with a behavioural ALU
// and a reference model built from plain arithmetic on each request.
module tb_alu_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [4:0]  req_op_i = '0;
  logic [31:0] req_a_i = '0;
  logic [31:0] req_b_i = '0;
  logic        req_cin_i = 1'b0;
  logic        req_rot_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_result_o;
  logic        rsp_flag_o;
  logic        busy_o;
  logic [4:0]  alu_sel_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_cin_o, alu_bin_o, alu_rot_o;
  logic [31:0] alu_result_i;
  logic        alu_cout_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  alu_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_cin_i    (req_cin_i),
    .req_rot_i    (req_rot_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_flag_o   (rsp_flag_o),
    .busy_o       (busy_o),
    .alu_sel_o    (alu_sel_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_cin_o    (alu_cin_o),
    .alu_bin_o    (alu_bin_o),
    .alu_rot_o    (alu_rot_o),
    .alu_result_i (alu_result_i),
    .alu_cout_i   (alu_cout_i)
  );

  // Behavioural ALU: returns {carry/borrow, result}; shifts move one bit.
  function automatic logic [32:0] aluModel(input logic [4:0] sel, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin,
                                           input logic bin, input logic rot);
    case (sel)
      5'd0: return {1'b0, a} + {1'b0, b} + {32'd0, cin};
      5'd1: return {1'b0, a} - {1'b0, b} - {32'd0, bin};
      5'd2: return rot ? {1'b0, a[0], a[31:1]} : {2'b00, a[31:1]};
      5'd3: return rot ? {1'b0, a[30:0], a[31]} : {1'b0, a[30:0], 1'b0};
      5'd4: return {1'b0, a & b};
      5'd5: return {1'b0, a | b};
      5'd6: return {1'b0, ~a};
      default: return 33'd0;
    endcase
  endfunction

  always_comb {alu_cout_i, alu_result_i} = aluModel(alu_sel_o, alu_a_o, alu_b_o,
                                                    alu_cin_o, alu_bin_o, alu_rot_o);

  function automatic logic [32:0] refResult(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin,
                                            input logic rot);
    logic [63:0] prod;
    logic [32:0] r;
    prod = 64'(a) * 64'(b);
    case (op)
      5'd0, 5'd1: return aluModel(op, a, b, cin, cin, rot);
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6: begin
        r = aluModel(op, a, b, cin, cin, rot);
        return {1'b0, r[31:0]};
      end
      5'd7:  return {1'b0, 31'd0, a > b};
      5'd8:  return {1'b0, 31'd0, a < b};
      5'd9:  return {1'b0, 31'd0, a == b};
      5'd10: return {1'b0, 31'd0, a != b};
      5'd11: return {1'b0, prod[31:0]};
      5'd12: return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int refLatency(input logic [4:0] op, input logic [31:0] b);
    if (op <= 6) return 2;
    if (op == 11) return 33;
    if (op == 12) return (b == 0) ? 1 : 33;
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issues one request from IDLE, waits for the response and checks it.
  task automatic applyStimulus(input string tag, input logic [4:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic rot, input int hold);
    logic [32:0] exp;
    int          cycles;
    logic        seen;
    exp = refResult(op, a, b, cin, rot);
    @(negedge clk_i);
    checkOutput({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_cin_i   = cin;
    req_rot_i   = rot;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 100) begin
      @(negedge clk_i);
      cycles++;
      if (op <= 6 && cycles == 1) begin
        checkOutput({tag, "_sel"}, 32'(alu_sel_o), 32'(op));
        checkOutput({tag, "_alua"}, alu_a_o, a);
      end
      if (rsp_valid_o) seen = 1'b1;
    end
    checkOutput({tag, "_lat"}, 32'(cycles), 32'(refLatency(op, b)));
    if (seen) begin
      checkOutput({tag, "_res"}, rsp_result_o, exp[31:0]);
      checkOutput({tag, "_flag"}, 32'(rsp_flag_o), 32'(exp[32]));
      repeat (hold) begin
        @(negedge clk_i);
        checkOutput({tag, "_hold"}, rsp_result_o, exp[31:0]);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1 rsp_ready_i = 1'b0;
      checkOutput({tag, "_done"}, 32'(rsp_valid_o), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    int          cycles;

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_result", rsp_result_o, 32'd0);
    @(negedge clk_i) rst_i = 1'b0;

    applyStimulus("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0);
    applyStimulus("mul", 5'd11, 32'd12345, 32'd678, 1'b0, 1'b0, 0);
    applyStimulus("mul_wrap", 5'd11, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 0);
    applyStimulus("div", 5'd12, 32'd100, 32'd7, 1'b0, 1'b0, 0);
    applyStimulus("div0", 5'd12, 32'd5, 32'd0, 1'b0, 1'b0, 0);
    applyStimulus("lt", 5'd8, 32'd3, 32'd9, 1'b0, 1'b0, 0);
    applyStimulus("eq", 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    applyStimulus("illegal", 5'd20, 32'd1, 32'd2, 1'b0, 1'b0, 0);
    applyStimulus("sub_borrow", 5'd1, 32'd3, 32'd5, 1'b1, 1'b0, 0);
    applyStimulus("shr_rot", 5'd2, 32'h8000_0001, 32'd0, 1'b0, 1'b1, 0);

    // Response backpressure with a competing request held on the bus.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op_i = 5'd8; req_a_i = 32'd3; req_b_i = 32'd9;
    @(posedge clk_i);
    #1;
    req_op_i = 5'd0; req_a_i = 32'd7; req_b_i = 32'd8; req_cin_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("bp_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("bp_result", rsp_result_o, 32'd1);
      checkOutput("bp_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
    checkOutput("bp_idle", 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    cycles = 0;
    while (!rsp_valid_o && cycles < 100) begin
      @(negedge clk_i);
      cycles++;
    end
    checkOutput("bp_next_lat", 32'(cycles), 32'd2);
    checkOutput("bp_next_res", rsp_result_o, 32'd15);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;

    // Reset in the middle of a divide.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op_i = 5'd12; req_a_i = 32'd1000; req_b_i = 32'd3;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("mrst_ready", 32'(req_ready_o), 32'd1);
    checkOutput("mrst_busy", 32'(busy_o), 32'd0);
    checkOutput("mrst_sel", 32'(alu_sel_o), 32'd0);
    checkOutput("mrst_alua", alu_a_o, 32'd0);
    checkOutput("mrst_alub", alu_b_o, 32'd0);
    checkOutput("mrst_result", rsp_result_o, 32'd0);
    @(negedge clk_i) rst_i = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (rsp_valid_o) checkOutput("mrst_norsp", 32'(rsp_valid_o), 32'd0);
    end
    checkOutput("mrst_valid", 32'(rsp_valid_o), 32'd0);
    applyStimulus("post_rst_add", 5'd0, 32'd2, 32'd3, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 14));
      if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(15, 31));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20));
      if ($urandom_range(0, 5) == 0) b = a;
      applyStimulus($sformatf("rand%0d_op%0d", i, op), op, a, b,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Controller that accepts ALU operation requests over a valid/ready handshake and drives the 32-bit ALU datapath's selector, operand, flag and rotate inputs.
- Single-cycle ops are issued directly to the ALU.
- Multiply and divide, which the ALU lacks, are sequenced as 32-iteration shift-add and restoring-divide loops that reuse the ALU adder and subtractor.
- Compare ops are resolved locally. Results return over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ITER_W, 6, width of the iteration counter; must hold WIDTH.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid & ready.
- req_op_i  in  5  opcode: 0 add, 1 sub, 2 shr, 3 shl, 4 and, 5 or, 6 not, 7 gt, 8 lt, 9 eq, 10 ne, 11 mul, 12 div.
- req_a_i  in  32  operand A.
- req_b_i  in  32  operand B.
- req_cin_i  in  1  carry-in (add) / borrow-in (sub).
- req_rot_i  in  1  rotate enable for shifts.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid & ready.
- rsp_result_o  out  32  result.
- rsp_flag_o  out  1  ALU carry/borrow for add/sub; 1 on divide-by-zero or illegal opcode; 0 otherwise.
- busy_o  out  1  high in any state except IDLE.
- alu_sel_o  out  5  ALU selector.
- alu_a_o  out  32  ALU operand A.
- alu_b_o  out  32  ALU operand B.
- alu_cin_o  out  1  ALU carry_in_flag.
- alu_bin_o  out  1  ALU borrow_in_flag.
- alu_rot_o  out  1  ALU rotate_shift.
- alu_result_i  in  32  ALU result.
- alu_cout_i  in  1  ALU carry_out_flag.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; every output and internal register is 0, except req_ready_o=1. Reset mid-operation aborts it; no response is produced.
- States: IDLE, EXEC, MUL, DIV, RESP.
- IDLE:
  - req_ready_o=1; ALU outputs driven to 0.
  - On accept, latch op/a/b/cin/rot.
  - op 0-6 -> EXEC.
  - op 7-10 -> RESP with result 32'd1 if the unsigned condition holds, else 32'd0.
  - op 11 -> MUL.
  - op 12 with b!=0 -> DIV.
  - op 12 with b=0 -> RESP with result 32'hFFFF_FFFF, flag=1.
  - op 13-31 -> RESP with result 0, flag=1.
- EXEC (1 cycle):
  - Drive alu_sel_o=op, alu_a_o=a, alu_b_o=b, alu_cin_o=alu_bin_o=cin, alu_rot_o=rot.
  - Capture alu_result_i and, for add/sub, alu_cout_i. Then -> RESP.
- MUL (32 cycles; unsigned, low 32 bits of product):
  - Registers: acc=0, mcand=a, mplier=b, cnt=0.
  - Each cycle: drive ALU add with alu_a_o=acc, alu_b_o=mcand, cin=0.
  - If mplier[0], acc<=alu_result_i.
  - mcand<<=1 (local), mplier>>=1, cnt++.
  - Exit after cnt=31 -> RESP with result=acc, flag=0.
- DIV (32 cycles; unsigned restoring division):
  - Registers: rem=0, quo=a, cnt=0.
  - Each cycle: trial={rem[30:0],quo[31]}; drive ALU sub with alu_a_o=trial, alu_b_o=b, bin=0.
  - The restore decision uses a local trial>=b compare; the ALU flag is not used.
  - If trial>=b: rem<=alu_result_i, quo<={quo[30:0],1}. Else: rem<=trial, quo<={quo[30:0],0}.
  - Exit after cnt=31 -> RESP with result=quo (quotient), flag=0.
- RESP:
  - rsp_valid_o=1; rsp_result_o and rsp_flag_o held stable until rsp_ready_i.
  - On handshake -> IDLE, rsp_valid_o<=0.
  - A request cannot be accepted in the same cycle as the response handshake.
- Latency (accept edge -> rsp_valid_o high):
  - compare, illegal opcode, div-by-zero: 1 cycle.
  - ops 0-6: 2 cycles.
  - mul/div: 33 cycles.
- Wrap-around: add/sub/mul results are truncated modulo 2^32.
- Request inputs are ignored while busy_o=1.

Decomposition:
- Package alu_seq_pkg:
  - OP_ADD…OP_DIV opcode localparams.
  - State encoding constants.
  - RESULT_DIV0 = 32'hFFFF_FFFF.
- One sub-module, alu_seq_compare: combinational unsigned gt/lt/eq/ne of two 32-bit operands, 2-bit mode in, 1-bit out. Reused for the DIV trial>=b check.

Test Plan:
- add a=32'hFFFF_FFFF, b=1, cin=0 -> ALU driven with sel=0 for 1 cycle; rsp_result=0, rsp_valid 2 cycles after accept.
- mul a=12345, b=678 -> rsp_result=8_369_910, flag=0, rsp_valid 33 cycles after accept. Also mul a=b=32'h0001_0000 -> result 0 (wrap).
- div a=100, b=7 -> result 14 after 33 cycles. Also div a=5, b=0 -> result 32'hFFFF_FFFF, flag=1, 1 cycle.
- lt a=3, b=9 -> result 1; eq a=b=32'hDEAD_BEEF -> result 1; op=20 -> result 0, flag=1.
- Hold rsp_ready_i=0 for 5 cycles -> result stable, req_ready_o=0, new request ignored; release -> next request accepted one cycle later.
- Assert rst_i at cycle 10 of a div -> all outputs 0 immediately, req_ready_o=1, no response; subsequent add 2+3 returns 5.
